// File: rtl/edge_detect_multi_if.sv
// Bundles the raw level inputs, per-channel controls and edge/level/flag
// outputs of edge_detect_multi; master drives levels and controls.
interface edge_detect_multi_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0]   level;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   clear;
  logic [N_CH-1:0]   tick;
  logic [N_CH-1:0]   level_db;
  logic [N_CH-1:0]   event_flag;
  logic              any_tick;

  modport master (
    output level, mode, clear,
    input  tick, level_db, event_flag, any_tick
  );

  modport slave (
    input  level, mode, clear,
    output tick, level_db, event_flag, any_tick
  );
endinterface

// File: rtl/edge_detect_multi.sv
// N-channel debounced edge detector: per-channel synchroniser, stability
// counter FSM, Moore edge ticks, debounced level and sticky event flag.
module edge_detect_multi #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               rst,
  edge_detect_multi_if.slave bus
);
  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  typedef enum logic [2:0] {
    LOW      = 3'd0,
    RISE_CHK = 3'd1,
    R_EDGE   = 3'd2,
    HIGH     = 3'd3,
    FALL_CHK = 3'd4,
    F_EDGE   = 3'd5
  } state_e;

  logic [N_CH-1:0] tick_s;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             s_s;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             flag_q;

    if (SYNC_STAGES == 0) begin : g_nosync
      assign s_s = bus.level[i];
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift the asynchronous level through the synchroniser chain
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q <= (sync_q << 1'b1) | SYNC_STAGES'(bus.level[i]);
        end
      end

      assign s_s = sync_q[SYNC_STAGES-1];
    end

    // Debounce FSM; the counter tracks stable samples after the first change
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= LOW;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          LOW: begin
            if (s_s) begin
              state_q <= RISE_CHK;
              cnt_q   <= '0;
            end
          end
          RISE_CHK: begin
            if (!s_s)                   state_q <= LOW;
            else if (cnt_q == CNT_LAST) state_q <= R_EDGE;
            else                        cnt_q   <= cnt_q + CNT_ONE;
          end
          R_EDGE: state_q <= HIGH;
          HIGH: begin
            if (!s_s) begin
              state_q <= FALL_CHK;
              cnt_q   <= '0;
            end
          end
          FALL_CHK: begin
            if (s_s)                    state_q <= HIGH;
            else if (cnt_q == CNT_LAST) state_q <= F_EDGE;
            else                        cnt_q   <= cnt_q + CNT_ONE;
          end
          F_EDGE: state_q <= LOW;
          default: begin
            state_q <= LOW;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    // Sticky edge flag: a tick outranks a coincident clear
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        flag_q <= 1'b0;
      end else if (tick_s[i]) begin
        flag_q <= 1'b1;
      end else if (bus.clear[i]) begin
        flag_q <= 1'b0;
      end else begin
        flag_q <= flag_q;
      end
    end

    // mode only gates the decode, never the state transitions
    assign tick_s[i] = ((state_q == R_EDGE) & bus.mode[2*i]) |
                       ((state_q == F_EDGE) & bus.mode[2*i+1]);
    assign bus.level_db[i]   = (state_q == R_EDGE) | (state_q == HIGH) |
                               (state_q == FALL_CHK);
    assign bus.event_flag[i] = flag_q;
  end

  assign bus.tick     = tick_s;
  assign bus.any_tick = |tick_s;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Self-checking bench: table of level segments with a latency scoreboard on
// the default instance, plus hand sequences on a SYNC=0/DB=1 instance.
module tb_edge_detect_multi;
  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam logic [7:0] M_MIX = 8'b11_10_01_01;

  typedef struct {
    int   cyc;
    int   ch;
    logic val;
    logic tk;
  } ev_t;

  typedef struct {
    logic [3:0] level;
    logic [7:0] mode;
    logic [3:0] clear;
    int         hold;
    logic [3:0] exp_db;
    logic [3:0] exp_flag;
  } row_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  ev_t        evq[$];
  logic [3:0] acc = 4'b0000;
  logic [3:0] exp_tick = 4'b0000;
  logic [3:0] exp_db = 4'b0000;
  logic [3:0] exp_flag = 4'b0000;
  row_t       rows [13];

  edge_detect_multi_if #(.N_CH(4)) bus1 ();
  edge_detect_multi_if #(.N_CH(4)) bus2 ();

  edge_detect_multi #(.N_CH(4), .SYNC_STAGES(SYNC), .DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  edge_detect_multi #(.N_CH(4), .SYNC_STAGES(0), .DB_CYCLES(1)) dut_fast (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drive a new level vector; accepted changes schedule their outcome at e0+SYNC+DB
  task automatic drive(input logic [3:0] lv, input bit accept);
    for (int ch = 0; ch < 4; ch++) begin
      ev_t e;
      if (accept && (lv[ch] != acc[ch])) begin
        e.cyc = cyc + 1 + SYNC + DB;
        e.ch  = ch;
        e.val = lv[ch];
        e.tk  = lv[ch] ? bus1.mode[2*ch] : bus1.mode[2*ch+1];
        evq.push_back(e);
        acc[ch] = lv[ch];
      end
    end
    bus1.level = lv;
  endtask

  // Scoreboard monitor, sampling on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_db   = 4'b0000;
        exp_flag = 4'b0000;
        if (mon_en) begin
          chk("mon_rst_tick", bus1.tick, 4'b0000);
          chk("mon_rst_flag", bus1.event_flag, 4'b0000);
        end
      end else if (mon_en) begin
        exp_tick = 4'b0000;
        for (int k = evq.size() - 1; k >= 0; k--) begin
          if (evq[k].cyc == cyc) begin
            exp_db[evq[k].ch]   = evq[k].val;
            exp_tick[evq[k].ch] = evq[k].tk;
            evq.delete(k);
          end else if (evq[k].cyc < cyc) begin
            chk("sb_stale", evq[k].cyc, cyc);
            evq.delete(k);
          end
        end
        chk("mon_tick", bus1.tick, exp_tick);
        chk("mon_any_tick", bus1.any_tick, |exp_tick);
        chk("mon_level_db", bus1.level_db, exp_db);
        chk("mon_event_flag", bus1.event_flag, exp_flag);
        exp_flag = exp_tick | (exp_flag & ~bus1.clear);
      end
    end
  end

  initial begin
    rows[0]  = '{4'b0001, M_MIX, 4'b0000, 10, 4'b0001, 4'b0001};
    rows[1]  = '{4'b0011, M_MIX, 4'b0000,  4, 4'b0001, 4'b0001};
    rows[2]  = '{4'b0001, M_MIX, 4'b0000, 10, 4'b0001, 4'b0001};
    rows[3]  = '{4'b0011, M_MIX, 4'b0000,  5, 4'b0001, 4'b0001};
    rows[4]  = '{4'b0011, M_MIX, 4'b0000, 10, 4'b0011, 4'b0011};
    rows[5]  = '{4'b0111, M_MIX, 4'b0000, 10, 4'b0111, 4'b0011};
    rows[6]  = '{4'b0011, M_MIX, 4'b0000, 10, 4'b0011, 4'b0111};
    rows[7]  = '{4'b1011, M_MIX, 4'b0000,  6, 4'b0011, 4'b0111};
    rows[8]  = '{4'b0011, M_MIX, 4'b0000, 10, 4'b0011, 4'b1111};
    rows[9]  = '{4'b1111, M_MIX, 4'b0000, 10, 4'b1111, 4'b1111};
    rows[10] = '{4'b0000, M_MIX, 4'b0000, 10, 4'b0000, 4'b1111};
    rows[11] = '{4'b1111, 8'h00, 4'b1111, 10, 4'b1111, 4'b0000};
    rows[12] = '{4'b0000, 8'h00, 4'b0000, 10, 4'b0000, 4'b0000};

    rst        = 1'b1;
    bus1.level = 4'b0000;
    bus1.mode  = M_MIX;
    bus1.clear = 4'b0000;
    bus2.level = 4'b0000;
    bus2.mode  = 8'b01_01_01_01;
    bus2.clear = 4'b0000;
    repeat (3) step();
    chk("reset_tick", bus1.tick, 4'b0000);
    chk("reset_level_db", bus1.level_db, 4'b0000);
    chk("reset_flag", bus1.event_flag, 4'b0000);
    chk("reset_any_tick", bus1.any_tick, 1'b0);
    chk("reset_fast_db", bus2.level_db, 4'b0000);
    rst    = 1'b0;
    mon_en = 1'b1;
    step();

    // SYNC=0, DB=1: a one-cycle pulse is rejected
    bus2.level = 4'b0001;
    step();
    chk("fast_pulse_chk_tick", bus2.tick, 4'b0000);
    bus2.level = 4'b0000;
    repeat (3) begin
      step();
      chk("fast_pulse_tick", bus2.tick, 4'b0000);
      chk("fast_pulse_db", bus2.level_db, 4'b0000);
    end

    // SYNC=0, DB=1: simultaneous rise on all channels, held two cycles
    bus2.level = 4'b1111;
    step();
    chk("fast_rise_e1_tick", bus2.tick, 4'b0000);
    chk("fast_rise_e1_db", bus2.level_db, 4'b0000);
    step();
    chk("fast_rise_e2_tick", bus2.tick, 4'b1111);
    chk("fast_rise_e2_any", bus2.any_tick, 1'b1);
    chk("fast_rise_e2_db", bus2.level_db, 4'b1111);
    chk("fast_rise_e2_flag", bus2.event_flag, 4'b0000);
    step();
    chk("fast_rise_e3_tick", bus2.tick, 4'b0000);
    chk("fast_rise_e3_any", bus2.any_tick, 1'b0);
    chk("fast_rise_e3_db", bus2.level_db, 4'b1111);
    chk("fast_rise_e3_flag", bus2.event_flag, 4'b1111);

    for (int r = 0; r < 13; r++) begin
      bus1.mode  = rows[r].mode;
      bus1.clear = rows[r].clear;
      drive(rows[r].level, rows[r].hold >= DB + 1);
      repeat (rows[r].hold) step();
      chk($sformatf("row%0d_level_db", r), bus1.level_db, rows[r].exp_db);
      chk($sformatf("row%0d_flag", r), bus1.event_flag, rows[r].exp_flag);
    end
    bus1.clear = 4'b0000;
    bus1.mode  = M_MIX;

    // Tick and clear in the same cycle: set wins; a lone clear then drops the flag
    drive(4'b1001, 1'b1);
    repeat (7) step();
    chk("race_tick0", bus1.tick[0], 1'b1);
    bus1.clear = 4'b0001;
    step();
    bus1.clear = 4'b0000;
    chk("race_set_wins", bus1.event_flag[0], 1'b1);
    step();
    bus1.clear = 4'b0001;
    step();
    bus1.clear = 4'b0000;
    chk("race_clear_alone", bus1.event_flag, 4'b1000);

    // Reset while ch0 is part way through the rise check
    drive(4'b0000, 1'b1);
    repeat (10) step();
    drive(4'b0001, 1'b0);
    repeat (5) step();
    rst = 1'b1;
    evq.delete();
    acc = 4'b0000;
    #1;
    chk("midrst_tick", bus1.tick, 4'b0000);
    chk("midrst_db", bus1.level_db, 4'b0000);
    chk("midrst_flag", bus1.event_flag, 4'b0000);
    chk("midrst_any", bus1.any_tick, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    drive(4'b0001, 1'b1);
    repeat (6) step();
    chk("postrst_early_tick", bus1.tick[0], 1'b0);
    step();
    chk("postrst_tick", bus1.tick[0], 1'b1);
    chk("postrst_db", bus1.level_db[0], 1'b1);
    step();
    chk("postrst_tick_end", bus1.tick[0], 1'b0);

    repeat (10) step();
    chk("scoreboard_drained", evq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
- N-channel debounced edge detector, the parametrised successor of the single-channel Moore edge detector.
- Each channel synchronises an asynchronous level input and debounces it with a stability counter.
- Emits one-cycle Moore ticks on rising, falling or both edges, selected per channel.
- Sits between raw board inputs (buttons, switches, external strobes) and control FSMs; also provides debounced levels and sticky event flags for polling logic.

Parameters:
- N_CH, 4, number of independent channels (>=1)
- SYNC_STAGES, 2, synchroniser flops per channel (0..3; 0 = level used directly)
- DB_CYCLES, 4, consecutive stable synchronised samples required after the first changed sample (>=1); counter width = max(1, clog2(DB_CYCLES))

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- level  in  N_CH  raw per-channel inputs, asynchronous to clk
- mode  in  2*N_CH  per-channel select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- clear  in  N_CH  per-channel clear of event_flag (single-cycle pulse)
- tick  out  N_CH  one-cycle edge pulse per channel
- level_db  out  N_CH  debounced level per channel
- event_flag  out  N_CH  sticky "edge seen" per channel
- any_tick  out  1  OR of tick

Behaviour:
- Reset (async assert, sync-to-clk deassert by system): all sync flops 0, every channel in LOW, counters 0, event_flag 0. Consequently tick 0, level_db 0, any_tick 0.
- Synchroniser: s[i] = level[i] delayed by SYNC_STAGES flops; s[i] = level[i] when SYNC_STAGES = 0.
- Per-channel FSM: states LOW, RISE_CHK, R_EDGE, HIGH, FALL_CHK, F_EDGE; unused encodings go to LOW.
  - LOW: s=1 -> RISE_CHK, cnt<=0; else stay.
  - RISE_CHK: s=0 -> LOW (bounce, no tick); else if cnt==DB_CYCLES-1 -> R_EDGE; else cnt<=cnt+1.
  - R_EDGE: lasts exactly one cycle -> HIGH unconditionally.
  - HIGH: s=0 -> FALL_CHK, cnt<=0; else stay.
  - FALL_CHK: s=1 -> HIGH (no tick); else if cnt==DB_CYCLES-1 -> F_EDGE; else cnt<=cnt+1.
  - F_EDGE: lasts exactly one cycle -> LOW unconditionally.
- Outputs (Moore, decoded from the state register):
  - tick[i] = (R_EDGE & mode[2i]) | (F_EDGE & mode[2i+1]); mode is combinational into the decode only and never affects state transitions.
  - level_db[i] = 1 in R_EDGE, HIGH, FALL_CHK; 0 otherwise.
- Latency: let e0 be the first clock edge sampling the new level, with level held stable thereafter. tick is high for exactly the one cycle following edge e0+SYNC_STAGES+DB_CYCLES. level_db changes at that same edge.
- Minimum stable width for acceptance: DB_CYCLES+1 consecutive s samples. A shorter pulse produces no tick and no level_db change.
- Back-to-back edges: after R_EDGE, a falling edge needs HIGH, then FALL_CHK, then F_EDGE. Minimum tick spacing is therefore DB_CYCLES+2 cycles.
- event_flag[i]:
  - set in the cycle after tick[i]=1;
  - cleared in the cycle after clear[i]=1;
  - set wins when tick and clear coincide;
  - clear with flag already 0 has no effect.
- mode=00: the FSM and level_db still run, but tick and event_flag never assert for that channel.
- Reset mid-debounce or mid-edge aborts without emitting a tick.
- A level high at reset release is a rising edge and ticks after the standard latency.
- Channels are fully independent; simultaneous edges on several channels tick in the same cycle.
- any_tick = |tick (combinational).

Test Plan:
1. Clean rise: N_CH=4, SYNC=2, DB=4, mode=01 all, level[0] 0->1 before edge 10 and held -> tick[0] high only in the cycle after edge 16; level_db[0] rises at edge 16; event_flag[0] set at edge 17; other channels stay 0.
2. Bounce reject: level[1] high for 4 cycles, then low -> no tick[1], level_db[1] stays 0. Then held high for 5+ cycles -> exactly one tick.
3. Mode coverage:
   - ch2 mode=10 with a full 0->1->0 cycle -> one tick, on the fall only;
   - mode=11 -> two ticks spaced >= DB+2 cycles;
   - mode=00 -> zero ticks, while level_db still follows.
4. Flag clear race: clear[0] asserted in the same cycle as tick[0] -> event_flag[0]=1 afterwards. clear[0] alone a cycle later -> flag 0.
5. Reset mid-operation: assert rst while ch0 is in RISE_CHK (cnt=2) -> all outputs 0 immediately. Deassert with level[0]=1 held -> tick[0] after SYNC+DB cycles from the first post-reset edge.
6. Boundary params: SYNC=0, DB=1 -> a level held 2 cycles ticks in the cycle after the second edge; a 1-cycle pulse does not tick. Simultaneous rises on all 4 channels -> tick=4'b1111 and any_tick=1 for one cycle.
